// File: rtl/seven_seg_scan_driver_if.sv
// rtl/seven_seg_scan_driver_if.sv - Data/control and display bundle for the seven-segment scan driver
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] i_data;
  logic                    i_load;
  logic                    i_blank_lz;
  logic [NUM_DIGITS-1:0]   i_blink_mask;
  logic [7*NUM_DIGITS-1:0] o_hex_all;
  logic [6:0]              o_seg;
  logic [NUM_DIGITS-1:0]   o_dig_sel;

  modport master (
    output i_data, i_load, i_blank_lz, i_blink_mask,
    input  o_hex_all, o_seg, o_dig_sel
  );

  modport slave (
    input  i_data, i_load, i_blank_lz, i_blink_mask,
    output o_hex_all, o_seg, o_dig_sel
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - Multi-digit hex display driver with static and scanned outputs
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic                    i_clk,
  input logic                    i_reset,
  seven_seg_scan_driver_if.slave bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = ACTIVE_LOW ? '1 : '0;

  // Patterns are held active-low (bit6=g .. bit0=a) and inverted at the output when needed.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [SCAN_W-1:0]       scan_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLINK_W-1:0]      blink_cnt_q;
  logic                    blink_hidden_q;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lead_zero;
  logic [6:0]              digit_al [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_d;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   sel_d;

  // Walk down from the top digit; a digit is blank while every nibble from it upward is zero.
  always_comb begin
    lz_blank  = '0;
    lead_zero = bus.i_blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (shadow_q[4*k +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      lz_blank[k] = lead_zero && (k != 0);
    end
  end

  always_comb begin
    hex_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_al[k] = decode(shadow_q[4*k +: 4]);
      if (lz_blank[k] || (blink_hidden_q && bus.i_blink_mask[k])) begin
        digit_al[k] = 7'h7F;
      end
      hex_d[7*k +: 7] = ACTIVE_LOW ? digit_al[k] : ~digit_al[k];
    end
  end

  // The scanned segment bus takes the same value the static register loads on this edge,
  // so o_seg always matches the selected o_hex_all slice.
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        seg_d    = hex_d[7*k +: 7];
        sel_d[k] = !ACTIVE_LOW;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shadow_q       <= '0;
      scan_cnt_q     <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
      hex_q          <= {NUM_DIGITS{SEG_OFF}};
      seg_q          <= SEG_OFF;
      sel_q          <= SEL_OFF;
    end else begin
      if (bus.i_load) begin
        shadow_q <= bus.i_data;
      end

      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end

      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q    <= '0;
        blink_hidden_q <= ~blink_hidden_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end

      hex_q <= hex_d;
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign bus.o_hex_all = hex_q;
  assign bus.o_seg     = seg_q;
  assign bus.o_dig_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - Directed bench for seven_seg_scan_driver in both polarities
module tb_seven_seg_scan_driver;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic        blank_lz;
  logic [3:0]  mask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_al ();
  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus_ah ();

  assign bus_al.i_data       = data;
  assign bus_al.i_load       = load;
  assign bus_al.i_blank_lz   = blank_lz;
  assign bus_al.i_blink_mask = mask;
  assign bus_ah.i_data       = data;
  assign bus_ah.i_load       = load;
  assign bus_ah.i_blank_lz   = blank_lz;
  assign bus_ah.i_blink_mask = mask;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b1)) dut_al (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_al.slave)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(4), .BLINK_DIV(16), .ACTIVE_LOW(1'b0)) dut_ah (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_ah.slave)
  );

  logic [27:0] al_hex_inv;
  logic [6:0]  al_seg_inv;
  logic [3:0]  al_sel_inv;
  assign al_hex_inv = ~bus_al.o_hex_all;
  assign al_seg_inv = ~bus_al.o_seg;
  assign al_sel_inv = ~bus_al.o_dig_sel;

  logic [3:0] sel_al   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pol();
    check("pol_hex", bus_ah.o_hex_all, al_hex_inv);
    check("pol_seg", bus_ah.o_seg, al_seg_inv);
    check("pol_sel", bus_ah.o_dig_sel, al_sel_inv);
  endtask

  initial begin
    reset    = 1'b1;
    data     = 16'h0;
    load     = 1'b0;
    blank_lz = 1'b0;
    mask     = 4'h0;

    // Reset state, then static decode of 89AF
    repeat (3) begin
      tick();
      check("rst_hex", bus_al.o_hex_all, 28'hFFFFFFF);
      check("rst_seg", bus_al.o_seg, 7'h7F);
      check("rst_sel", bus_al.o_dig_sel, 4'hF);
      check("rst_hex_ah", bus_ah.o_hex_all, 28'h0);
      check("rst_sel_ah", bus_ah.o_dig_sel, 4'h0);
    end
    reset = 1'b0;
    data  = 16'h89AF;
    load  = 1'b1;
    tick();
    check("first_sel", bus_al.o_dig_sel, 4'b1110);
    load = 1'b0;
    tick();
    check("static_89af", bus_al.o_hex_all, {7'h00, 7'h10, 7'h08, 7'h0E});
    check_pol();

    // Scan walk over 1234, one full frame plus the wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data  = 16'h1234;
    load  = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      load = 1'b0;
      check("scan_sel", bus_al.o_dig_sel, sel_al[(k / 4) % 4]);
      check("scan_seg", bus_al.o_seg, (k == 0) ? 7'h40 : seg_1234[(k / 4) % 4]);
    end

    // Leading-zero blanking
    data     = 16'h0050;
    blank_lz = 1'b1;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("lz_0050", bus_al.o_hex_all, {7'h7F, 7'h7F, 7'h12, 7'h40});
    data = 16'h0000;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("lz_0000", bus_al.o_hex_all, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check_pol();
    blank_lz = 1'b0;
    tick();
    check("lz_off", bus_al.o_hex_all, {7'h40, 7'h40, 7'h40, 7'h40});

    // Blink on digit 1: visible edges 2..16, hidden 17..32, visible again from 33
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data  = 16'h1111;
    load  = 1'b1;
    mask  = 4'b0010;
    tick();
    load = 1'b0;
    for (int e = 2; e <= 40; e++) begin
      tick();
      check("blink", bus_al.o_hex_all,
            {7'h79, 7'h79, (e >= 17 && e <= 32) ? 7'h7F : 7'h79, 7'h79});
    end
    mask = 4'h0;

    // Load coinciding with the 0->1 select change, then reset while digit 2 is selected
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data  = 16'h1234;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    data = 16'hFFFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("adv_sel", bus_al.o_dig_sel, 4'b1101);
    check("adv_sel_ah", bus_ah.o_dig_sel, 4'b0010);
    check("adv_seg_old", bus_al.o_seg, 7'h30);
    check("adv_hex_old", bus_al.o_hex_all, {7'h79, 7'h24, 7'h30, 7'h19});
    tick();
    check("adv_seg_new", bus_al.o_seg, 7'h0E);
    check("adv_hex_new", bus_al.o_hex_all, {7'h0E, 7'h0E, 7'h0E, 7'h0E});
    repeat (4) tick();
    check("mid_sel2", bus_al.o_dig_sel, 4'b1011);
    reset = 1'b1;
    tick();
    check("mid_rst_sel", bus_al.o_dig_sel, 4'hF);
    check("mid_rst_seg", bus_al.o_seg, 7'h7F);
    check("mid_rst_hex", bus_al.o_hex_all, 28'hFFFFFFF);
    reset = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("restart_sel", bus_al.o_dig_sel, (j <= 4) ? 4'b1110 : 4'b1101);
    end
    check_pol();

    // Polarity with data 0008
    data = 16'h0008;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("pol_ah_hex", bus_ah.o_hex_all, {7'h3F, 7'h3F, 7'h3F, 7'h7F});
    check("pol_al_hex", bus_al.o_hex_all, {7'h40, 7'h40, 7'h40, 7'h00});
    check_pol();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
